// File: rtl/main_sched_pkg.sv
// Shared types and constants for main_function_scheduler and its arbiter.
package main_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } sched_state_t;

   localparam int OPW  = 8;
   localparam int RESW = 24;
   localparam logic [RESW-1:0] TIMEOUT_RESULT = 24'hFFFFFF;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/main_function_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request at or after i_ptr, wrapping modulo N.
module rr_arbiter
   import main_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   i_req,
   input  logic [IDW-1:0] i_ptr,
   output logic [N-1:0]   o_pick,
   output logic [IDW-1:0] o_idx,
   output logic           o_any
);

   // scan the requesters starting at the pointer, keep the first hit
   always_comb begin
      int j;
      j      = 0;
      o_pick = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[j]) begin
            o_pick[j] = 1'b1;
            o_idx     = IDW'(j);
            o_any     = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/main_function_scheduler.sv
// Round-robin scheduler sharing one main_function datapath between N requesters.
// Optional watchdog abort in WAIT is enabled by defining SCHED_TIMEOUT_EN.
module main_function_scheduler
   import main_sched_pkg::*;
#(
   parameter int N              = 4,
   parameter int IDW            = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N-1:0]      req,
   input  logic [N*OPW-1:0]  a_in,
   input  logic [N*OPW-1:0]  b_in,
   output logic [N-1:0]      gnt,
   output logic [N-1:0]      done,
   output logic [RESW-1:0]   result_out,
   output logic [IDW-1:0]    owner,
   output logic              idle,
   output logic              err,
   output logic              fn_enable,
   output logic              fn_reset,
   output logic [OPW-1:0]    fn_a,
   output logic [OPW-1:0]    fn_b,
   input  logic              fn_busy,
   input  logic              fn_finish,
   input  logic [RESW-1:0]   fn_result
);

   sched_state_t    r_state, w_state_nxt;
   logic [N-1:0]    r_gnt, w_gnt_nxt;
   logic [N-1:0]    r_done, w_done_nxt;
   logic [RESW-1:0] r_result, w_result_nxt;
   logic [IDW-1:0]  r_owner, w_owner_nxt;
   logic [IDW-1:0]  r_ptr, w_ptr_nxt;
   logic            r_idle, w_idle_nxt;
   logic            r_fn_en, w_fn_en_nxt;
   logic [OPW-1:0]  r_fn_a, w_fn_a_nxt;
   logic [OPW-1:0]  r_fn_b, w_fn_b_nxt;
   logic [N-1:0]    w_pick;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
`ifdef SCHED_TIMEOUT_EN
   logic [31:0]     r_cnt, w_cnt_nxt;
   logic            r_err, w_err_nxt;
   logic            r_fn_rst, w_fn_rst_nxt;
`else
   logic            w_unused_cfg;
`endif

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .i_req  (req),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // next-state and next-output decode
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_done_nxt   = '0;
      w_result_nxt = r_result;
      w_owner_nxt  = r_owner;
      w_ptr_nxt    = r_ptr;
      w_idle_nxt   = r_idle;
      w_fn_en_nxt  = 1'b0;
      w_fn_a_nxt   = r_fn_a;
      w_fn_b_nxt   = r_fn_b;
`ifdef SCHED_TIMEOUT_EN
      w_cnt_nxt    = r_cnt;
      w_err_nxt    = 1'b0;
      w_fn_rst_nxt = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_any && !fn_busy) begin
               w_state_nxt = LAUNCH;
               w_gnt_nxt   = w_pick;
               w_owner_nxt = w_idx;
               w_fn_a_nxt  = a_in[int'(w_idx)*OPW +: OPW];
               w_fn_b_nxt  = b_in[int'(w_idx)*OPW +: OPW];
               w_fn_en_nxt = 1'b1;
               w_idle_nxt  = 1'b0;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         LAUNCH: begin
            w_state_nxt = WAIT;
`ifdef SCHED_TIMEOUT_EN
            w_cnt_nxt   = 32'd0;
`endif
         end
         WAIT: begin
            if (fn_finish) begin
               w_state_nxt  = DONE;
               w_result_nxt = fn_result;
               w_done_nxt   = r_gnt;
`ifdef SCHED_TIMEOUT_EN
            end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
               // watchdog abort: the owner still gets a done, with the error marker result
               w_state_nxt  = DONE;
               w_result_nxt = TIMEOUT_RESULT;
               w_done_nxt   = r_gnt;
               w_err_nxt    = 1'b1;
               w_fn_rst_nxt = 1'b1;
            end else begin
               w_cnt_nxt    = r_cnt + 32'd1;
            end
`else
            end else begin
               w_state_nxt  = WAIT;
            end
`endif
         end
         DONE: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = IDW'(wrap_inc(int'(r_owner), N));
            w_idle_nxt  = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_idle_nxt  = 1'b1;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_gnt    <= '0;
         r_done   <= '0;
         r_result <= '0;
         r_owner  <= '0;
         r_ptr    <= '0;
         r_idle   <= 1'b1;
         r_fn_en  <= 1'b0;
         r_fn_a   <= '0;
         r_fn_b   <= '0;
`ifdef SCHED_TIMEOUT_EN
         r_cnt    <= 32'd0;
         r_err    <= 1'b0;
         r_fn_rst <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_done   <= w_done_nxt;
         r_result <= w_result_nxt;
         r_owner  <= w_owner_nxt;
         r_ptr    <= w_ptr_nxt;
         r_idle   <= w_idle_nxt;
         r_fn_en  <= w_fn_en_nxt;
         r_fn_a   <= w_fn_a_nxt;
         r_fn_b   <= w_fn_b_nxt;
`ifdef SCHED_TIMEOUT_EN
         r_cnt    <= w_cnt_nxt;
         r_err    <= w_err_nxt;
         r_fn_rst <= w_fn_rst_nxt;
`endif
      end
   end

   assign gnt        = r_gnt;
   assign done       = r_done;
   assign result_out = r_result;
   assign owner      = r_owner;
   assign idle       = r_idle;
   assign fn_enable  = r_fn_en;
   assign fn_a       = r_fn_a;
   assign fn_b       = r_fn_b;
`ifdef SCHED_TIMEOUT_EN
   assign err        = r_err;
   assign fn_reset   = ~reset | r_fn_rst;
`else
   assign err          = 1'b0;
   assign fn_reset     = ~reset;
   assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: doc/main_function_scheduler.md
Name: main_function_scheduler

Overview:
- Round-robin scheduler that shares one main_function datapath (8-bit a/b operands, 24-bit result) between N requesters.
- Grants one requester at a time and latches its operands. Sequences the datapath with enable/finish, then returns the result to the owner with a one-cycle done pulse.
- Sits between requester logic (switch/button front-ends, test sequencers) and a single main_function instance, one level below the board top.

Parameters:
- N, 4, number of requesters (2..8)
- IDW, 2, owner index width, equal to clog2(N)
- TIMEOUT_CYCLES, 1_000_000, watchdog limit in clock cycles (used only with SCHED_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
- req  in  N  per-requester request level
- a_in  in  N*8  operand a, lane i = bits [8i+7:8i]
- b_in  in  N*8  operand b, same packing as a_in
- gnt  out  N  one-hot grant, high from grant through the done cycle
- done  out  N  one-hot, one-cycle pulse when the result is valid
- result_out  out  24  result, valid in the done cycle and held afterwards
- owner  out  IDW  index of the current or last granted requester
- idle  out  1  high in IDLE
- err  out  1  one-cycle pulse on watchdog abort; tied 0 without the macro
- fn_enable  out  1  start pulse to main_function
- fn_reset  out  1  active-high reset to main_function
- fn_a  out  8  latched operand a
- fn_b  out  8  latched operand b
- fn_busy  in  1  main_function busy
- fn_finish  in  1  main_function finish pulse
- fn_result  in  24  main_function result

Behaviour:
- Reset state:
  - state=IDLE; gnt=0, done=0, err=0, fn_enable=0, fn_reset=0.
  - fn_a=0, fn_b=0, result_out=0, owner=0, rr pointer=0, idle=1.
- IDLE:
  - If any req is high and fn_busy=0, pick the first requester at or after rr_ptr, wrapping modulo N.
  - At the next edge: latch fn_a/fn_b from that requester's lane, set gnt[i] and owner=i, then go to LAUNCH.
  - If fn_busy=1, stay in IDLE.
- LAUNCH: fn_enable=1 for exactly one cycle, then WAIT. fn_finish is ignored in LAUNCH.
- WAIT:
  - Hold fn_enable=0 and keep fn_a/fn_b stable.
  - On the edge where fn_finish=1: capture fn_result into result_out and go to DONE.
- DONE:
  - done[owner]=1 for one cycle; gnt stays high through this cycle.
  - At the next edge: rr_ptr=(owner+1) mod N, gnt=0, return to IDLE.
- Latency: req sampled at cycle 0 -> gnt at cycle 1 -> fn_enable in cycle 1 -> done one cycle after fn_finish is sampled. Minimum request-to-done is 3 + datapath latency.
- Requests and operands:
  - req is ignored after grant; deasserting it mid-operation does not abort, and done still pulses.
  - Operand changes after grant are ignored.
- Back-to-back: a requester still holding req after its done is re-eligible only after all other active requesters, because the pointer has advanced.
- Simultaneous requests: strict round-robin from rr_ptr. With rr_ptr=0 and req=4'b1111, the grant order is 0,1,2,3,0,…
- Pointer wrap: owner=N-1 sets rr_ptr=0.
- Reset asserted mid-operation: everything returns to the reset state asynchronously. fn_reset is driven 1 while reset=0, so main_function is reset along with the scheduler.
- No requests: the block stays in IDLE with all outputs stable.

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- With the macro:
  - A 32-bit cycle counter clears on entering WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES-1 without fn_finish: pulse err=1 for one cycle and fn_reset=1 for one cycle.
  - The owner receives done with result_out=24'hFFFFFF; rr_ptr advances, and the state goes to IDLE.
  - If fn_finish and the timeout occur in the same cycle, fn_finish wins.
- Without the macro: no counter exists, err is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package main_sched_pkg:
  - state enum IDLE/LAUNCH/WAIT/DONE
  - OPW=8, RESW=24
  - TIMEOUT_RESULT=24'hFFFFFF
- Sub-module rr_arbiter (parameter N): combinational req + rr_ptr -> one-hot pick plus index. The FSM and latches stay in the top module.

Test Plan:
- Reset: hold reset=0 with random req -> all outputs at their reset values and fn_reset=1; release reset -> idle=1.
- Single request: req=4'b0001, a_in lane0=12, b_in lane0=5, model finishes 6 cycles after enable with result 17 -> gnt[0] at cycle 1, one fn_enable pulse with fn_a=12/fn_b=5, done[0] with result_out=17.
- Contention: req=4'b0101 held, rr_ptr=0 -> service order 0,2,0,2; each done is one-hot and matches its owner's operands.
- Wrap and fairness: req=4'b1111 for 8 operations -> owner sequence 0,1,2,3,0,1,2,3.
- Reset mid-operation: assert reset=0 during WAIT -> gnt=0 immediately, no done pulse; the next request starts from owner 0.
- Timeout (SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16): model never finishes -> err and fn_reset pulse at WAIT cycle 16, done[owner] with result_out=24'hFFFFFF.
